// File: rtl/mmc_init_sequencer.sv
// mmc_init_sequencer
//   Drives the SPI-mode MMC/SD power-up sequence. It sends P_DUMMY_BYTES
//   0xFF bytes with CS deasserted, then runs CMD0 once. It then repeats CMD1
//   until the card reports ready or P_CMD1_RETRY attempts have been used.
//   This block owns the single MMC byte-transfer interface. It forwards the
//   REQ/CS/DATA of whichever command sub-layer is currently active.
//
// Ports
//   iCLOCK, inRESET (sync, active low), iRESET_SYNC (sync soft reset, high)
//   iINIT_START                start / restart pulse (IDLE, DONE, ERROR only)
//   oINIT_BUSY/DONE/ERROR      sequence status; DONE and ERROR are sticky
//   oRETRY_COUNT               CMD1 attempts completed (saturating)
//   oCMD0_START, iCMD0_END, iCMD0_REQ/CS/DATA    CMD0 sub-layer handshake + bus
//   oCMD1_START, iCMD1_END, iCMD1_IDLE, iCMD1_REQ/CS/DATA  CMD1 sub-layer
//   oMMC_REQ/CS/DATA, iMMC_BUSY                  MMC byte layer
module mmc_init_sequencer #(
  parameter int P_DUMMY_BYTES = 10,
  parameter int P_CMD1_RETRY  = 1000,
  parameter int P_RETRY_W     = 16
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iRESET_SYNC,
  input  logic                 iINIT_START,
  output logic                 oINIT_BUSY,
  output logic                 oINIT_DONE,
  output logic                 oINIT_ERROR,
  output logic [P_RETRY_W-1:0] oRETRY_COUNT,
  output logic                 oCMD0_START,
  input  logic                 iCMD0_END,
  input  logic                 iCMD0_REQ,
  input  logic                 iCMD0_CS,
  input  logic [7:0]           iCMD0_DATA,
  output logic                 oCMD1_START,
  input  logic                 iCMD1_END,
  input  logic                 iCMD1_IDLE,
  input  logic                 iCMD1_REQ,
  input  logic                 iCMD1_CS,
  input  logic [7:0]           iCMD1_DATA,
  output logic                 oMMC_REQ,
  input  logic                 iMMC_BUSY,
  output logic                 oMMC_CS,
  output logic [7:0]           oMMC_DATA
);

  localparam int DUMMY_W = (P_DUMMY_BYTES < 1) ? 1 : $clog2(P_DUMMY_BYTES + 1);
  localparam logic [DUMMY_W-1:0]   DUMMY_MAX = DUMMY_W'(P_DUMMY_BYTES);
  localparam logic [DUMMY_W-1:0]   DUMMY_ONE = DUMMY_W'(1);
  localparam logic [DUMMY_W-1:0]   DUMMY_ZERO = DUMMY_W'(0);
  localparam logic [P_RETRY_W-1:0] RETRY_MAX = P_RETRY_W'(P_CMD1_RETRY);
  localparam logic [P_RETRY_W-1:0] RETRY_ONE = P_RETRY_W'(1);
  localparam logic [P_RETRY_W-1:0] RETRY_ZERO = P_RETRY_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DUMMY    = 3'd1,
    ST_C0_START = 3'd2,
    ST_C0_WAIT  = 3'd3,
    ST_C1_START = 3'd4,
    ST_C1_WAIT  = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;

  state_t               state_r;
  logic [DUMMY_W-1:0]   dummy_cnt_r;
  logic [P_RETRY_W-1:0] retry_cnt_r;
  logic                 done_r;
  logic                 error_r;
  logic                 busy_r;
  logic                 cmd0_start_r;
  logic                 cmd1_start_r;

  logic                 dummy_req_s;
  logic [P_RETRY_W-1:0] retry_inc_s;
  logic                 mmc_req_s;
  logic                 mmc_cs_s;
  logic [7:0]           mmc_data_s;

  // A dummy byte is requested only while the byte layer is free and bytes remain.
  assign dummy_req_s = (state_r == ST_DUMMY) && !iMMC_BUSY && (dummy_cnt_r < DUMMY_MAX);

  // Saturating attempt counter value after the current CMD1 completes.
  always_comb begin
    retry_inc_s = retry_cnt_r;
    if (retry_cnt_r < RETRY_MAX) begin
      retry_inc_s = retry_cnt_r + RETRY_ONE;
    end else begin
      retry_inc_s = retry_cnt_r;
    end
  end

  // Sequencer FSM with counters, sticky flags and registered status/start outputs.
  // The start pulses and busy flag are loaded with the value of the state being
  // entered, so they line up exactly with the corresponding state.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET || iRESET_SYNC) begin
      state_r      <= ST_IDLE;
      dummy_cnt_r  <= DUMMY_ZERO;
      retry_cnt_r  <= RETRY_ZERO;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      busy_r       <= 1'b0;
      cmd0_start_r <= 1'b0;
      cmd1_start_r <= 1'b0;
    end else begin
      cmd0_start_r <= 1'b0;
      cmd1_start_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (iINIT_START) begin
            state_r     <= ST_DUMMY;
            dummy_cnt_r <= DUMMY_ZERO;
            retry_cnt_r <= RETRY_ZERO;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            busy_r      <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        ST_DUMMY: begin
          if (dummy_req_s) begin
            dummy_cnt_r <= dummy_cnt_r + DUMMY_ONE;
          end else if (dummy_cnt_r == DUMMY_MAX) begin
            state_r      <= ST_C0_START;
            cmd0_start_r <= 1'b1;
          end else begin
            state_r <= ST_DUMMY;
          end
        end
        ST_C0_START: begin
          state_r <= ST_C0_WAIT;
        end
        ST_C0_WAIT: begin
          if (iCMD0_END) begin
            state_r      <= ST_C1_START;
            cmd1_start_r <= 1'b1;
          end else begin
            state_r <= ST_C0_WAIT;
          end
        end
        ST_C1_START: begin
          state_r <= ST_C1_WAIT;
        end
        ST_C1_WAIT: begin
          if (iCMD1_END) begin
            retry_cnt_r <= retry_inc_s;
            if (!iCMD1_IDLE) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else if (retry_inc_s < RETRY_MAX) begin
              state_r      <= ST_C1_START;
              cmd1_start_r <= 1'b1;
            end else begin
              state_r <= ST_ERROR;
              error_r <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_C1_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-interface mux: dummy bytes, the active sub-layer, or the idle bus.
  always_comb begin
    mmc_req_s  = 1'b0;
    mmc_cs_s   = 1'b1;
    mmc_data_s = 8'hFF;
    case (state_r)
      ST_DUMMY: begin
        mmc_req_s = dummy_req_s;
      end
      ST_C0_WAIT: begin
        mmc_req_s  = iCMD0_REQ;
        mmc_cs_s   = iCMD0_CS;
        mmc_data_s = iCMD0_DATA;
      end
      ST_C1_WAIT: begin
        mmc_req_s  = iCMD1_REQ;
        mmc_cs_s   = iCMD1_CS;
        mmc_data_s = iCMD1_DATA;
      end
      default: begin
        mmc_req_s  = 1'b0;
        mmc_cs_s   = 1'b1;
        mmc_data_s = 8'hFF;
      end
    endcase
  end

  assign oMMC_REQ     = mmc_req_s;
  assign oMMC_CS      = mmc_cs_s;
  assign oMMC_DATA    = mmc_data_s;
  assign oINIT_BUSY   = busy_r;
  assign oINIT_DONE   = done_r;
  assign oINIT_ERROR  = error_r;
  assign oRETRY_COUNT = retry_cnt_r;
  assign oCMD0_START  = cmd0_start_r;
  assign oCMD1_START  = cmd1_start_r;

endmodule

// File: doc/mmc_init_sequencer.md
Name: mmc_init_sequencer

Overview:
- Sequences SPI-mode MMC/SD card initialisation: power-up dummy bytes, then CMD0, then repeated CMD1 until the card leaves idle.
- Owns the single MMC byte-transfer interface. It arbitrates (muxes) REQ/CS/DATA from the CMD0 and CMD1 command sub-layers onto that interface.
- iMMC_BUSY, iMMC_VALID and iMMC_DATA are wired directly to the sub-layers at top level. This block only observes iMMC_BUSY.

Parameters:
- P_DUMMY_BYTES, 10, number of 0xFF bytes sent with CS high before CMD0 (gives 80 SPI clocks).
- P_CMD1_RETRY, 1000, maximum CMD1 attempts before error; must be at least 1.
- P_RETRY_W, 16, width of the retry counter and of oRETRY_COUNT.

Ports:
- iCLOCK  in  1  single clock.
- inRESET  in  1  synchronous, active-low reset.
- iRESET_SYNC  in  1  synchronous soft reset, active high; same effect as inRESET.
- iINIT_START  in  1  start/restart pulse.
- oINIT_BUSY  out  1  sequence in progress.
- oINIT_DONE  out  1  sticky success flag.
- oINIT_ERROR  out  1  sticky CMD1 retry-exhausted flag.
- oRETRY_COUNT  out  P_RETRY_W  CMD1 attempts completed.
- oCMD0_START  out  1  one-cycle start pulse to the CMD0 sub-layer.
- iCMD0_END  in  1  CMD0 sub-layer finished (R1 = 0x01).
- iCMD0_REQ / iCMD0_CS / iCMD0_DATA  in  1/1/8  CMD0 sub-layer byte-interface outputs.
- oCMD1_START  out  1  one-cycle start pulse to the CMD1 sub-layer.
- iCMD1_END  in  1  CMD1 sub-layer finished.
- iCMD1_IDLE  in  1  qualified by iCMD1_END; 1 means the card is still idle (R1 = 0x01), 0 means ready (R1 = 0x00).
- iCMD1_REQ / iCMD1_CS / iCMD1_DATA  in  1/1/8  CMD1 sub-layer byte-interface outputs.
- oMMC_REQ  out  1  byte request to the MMC byte layer.
- iMMC_BUSY  in  1  byte layer busy.
- oMMC_CS  out  1  chip select, 1 = deselected.
- oMMC_DATA  out  8  byte to send.

Behaviour:
- Reset (inRESET low or iRESET_SYNC high at a clock edge):
  - state goes to IDLE; dummy counter and retry counter go to 0; DONE and ERROR go to 0.
  - Resulting outputs: oMMC_REQ=0, oMMC_CS=1, oMMC_DATA=0xFF, start pulses 0, oINIT_BUSY=0.
  - A reset mid-sequence aborts immediately; sub-layers receive no further start.
- States (3-bit): IDLE, DUMMY, C0_START, C0_WAIT, C1_START, C1_WAIT, DONE, ERROR.
- IDLE, DONE, ERROR: on iINIT_START go to DUMMY, clear DONE, ERROR, dummy counter and retry counter. In every other state iINIT_START is ignored.
- DUMMY:
  - oMMC_CS=1, oMMC_DATA=0xFF, oMMC_REQ = !iMMC_BUSY && (dummy_cnt < P_DUMMY_BYTES).
  - dummy_cnt increments on each cycle oMMC_REQ=1.
  - When dummy_cnt == P_DUMMY_BYTES, go to C0_START on the next edge.
- C0_START: oCMD0_START=1 for exactly this one cycle; oMMC_REQ=0, CS=1, DATA=0xFF. Next state C0_WAIT.
- C0_WAIT:
  - oMMC_REQ/CS/DATA = iCMD0_REQ/iCMD0_CS/iCMD0_DATA, combinational pass-through.
  - On iCMD0_END go to C1_START.
- C1_START: oCMD1_START=1 for one cycle; idle bus values. Next state C1_WAIT.
- C1_WAIT:
  - Pass through iCMD1_* signals.
  - On iCMD1_END, retry_cnt increments by 1, then:
    - iCMD1_IDLE=0 → DONE.
    - iCMD1_IDLE=1 and incremented retry_cnt < P_CMD1_RETRY → C1_START.
    - otherwise → ERROR.
- DONE: oINIT_DONE=1. ERROR: oINIT_ERROR=1. Both hold until iINIT_START or reset.
- oINIT_BUSY=1 in DUMMY, C0_*, C1_*.
- Outside DUMMY and the *_WAIT states, the bus is always REQ=0, CS=1, DATA=0xFF.
- The sub-layer not selected is ignored: its REQ is never forwarded.
- All state, counters and flags are registered. Bus outputs are combinational from state, counters, iMMC_BUSY and the selected sub-layer inputs.
- oRETRY_COUNT = retry_cnt, which saturates at P_CMD1_RETRY and does not wrap.

Test Plan:
- Reset held low 3 cycles with iINIT_START=1 → state IDLE, oMMC_CS=1, oMMC_DATA=0xFF, oMMC_REQ=0, DONE=ERROR=BUSY=0.
- iINIT_START pulse, iMMC_BUSY=0 → exactly 10 REQ cycles with CS=1 and DATA=0xFF, then a single-cycle oCMD0_START pulse; oINIT_BUSY=1 throughout.
- During DUMMY, iMMC_BUSY toggled 1,0,1,0 → REQ only on busy-low cycles; still exactly 10 counted bytes.
- In C0_WAIT, drive iCMD0_DATA=0x40, CS=0, REQ=1 and iCMD1_REQ=1 → bus shows 0x40/CS=0/REQ=1 with CMD1 ignored; iCMD0_END → oCMD1_START one cycle later.
- CMD1 replies idle twice then ready → three oCMD1_START pulses, oRETRY_COUNT=3, oINIT_DONE=1, oINIT_BUSY=0.
- With P_CMD1_RETRY=4 and CMD1 always idle → 4 start pulses, oINIT_ERROR=1, oRETRY_COUNT=4. A later iINIT_START clears ERROR and re-enters DUMMY. iRESET_SYNC asserted in C1_WAIT → IDLE next cycle, flags clear.
